// File: rtl/gpio_irq_ctrl.sv
// Interrupt controller for a GPIO bank: fixed-priority arbitration of sticky pin levels,
// CPU request/ack handshake, per-pin clear pulse and clear-timeout error tracking.
//
// state | meaning
// IDLE  | no request outstanding, arbitrate eligible sources
// PEND  | request presented to the CPU, waiting for ack or withdraw
// CLEAR | IRQRES pulse high on the served pin for RES_PULSE cycles
// WAIT  | pulse done, waiting for the pin to drop INTR or time out
module gpio_irq_ctrl #(
    parameter int N_SRC     = 4,
    parameter int RES_PULSE = 2,
    parameter int TMO       = 8,
    localparam int ID_W     = $clog2(N_SRC)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_SRC-1:0] i_intr_in,
    input  logic [N_SRC-1:0] i_irq_mask,
    output logic             o_cpu_irq,
    output logic [ID_W-1:0]  o_cpu_id,
    input  logic             i_cpu_ack,
    output logic [N_SRC-1:0] o_irqres,
    output logic             o_busy,
    output logic [N_SRC-1:0] o_err,
    input  logic [N_SRC-1:0] i_err_clr
);

    localparam int CNT_MAX_VAL = (RES_PULSE > TMO) ? RES_PULSE : TMO;
    localparam int CNT_W       = $clog2(CNT_MAX_VAL) + 1;

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_CLEAR, S_WAIT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_id_nxt;
    logic               r_cpu_irq;
    logic               w_cpu_irq_nxt;
    logic [ID_W-1:0]    r_cpu_id;
    logic [ID_W-1:0]    w_cpu_id_nxt;
    logic [N_SRC-1:0]   r_irqres;
    logic [N_SRC-1:0]   w_irqres_nxt;
    logic [N_SRC-1:0]   r_err;
    logic [N_SRC-1:0]   w_err_set;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               r_busy;

    logic [N_SRC-1:0]   w_elig;
    logic [ID_W-1:0]    w_winner;
    logic               w_cur_elig;
    logic               w_cur_intr;
    logic               w_pulse_done;
    logic               w_tmo_hit;
    logic [N_SRC-1:0]   w_onehot;

    // Errored sources stay out of arbitration so a stuck pin cannot livelock the controller.
    assign w_elig       = i_intr_in & i_irq_mask & ~r_err;
    assign w_cur_elig   = w_elig[r_id];
    assign w_cur_intr   = i_intr_in[r_id];
    assign w_pulse_done = (r_cnt == CNT_W'(RES_PULSE - 1));
    assign w_tmo_hit    = (r_cnt == CNT_W'(TMO - 1));
    assign w_cnt_inc    = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_onehot     = N_SRC'(1) << r_id;

    always_comb begin
        w_winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) w_winner = ID_W'(i);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_id      <= '0;
            r_cpu_irq <= 1'b0;
            r_cpu_id  <= '0;
            r_irqres  <= '0;
            r_err     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_id      <= w_id_nxt;
            r_cpu_irq <= w_cpu_irq_nxt;
            r_cpu_id  <= w_cpu_id_nxt;
            r_irqres  <= w_irqres_nxt;
            r_err     <= (r_err & ~i_err_clr) | w_err_set;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|w_elig) w_state_nxt = S_PEND;
            S_PEND: begin
                if (!w_cur_elig)    w_state_nxt = S_IDLE;
                else if (i_cpu_ack) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: if (w_pulse_done) w_state_nxt = S_WAIT;
            S_WAIT:  if (!w_cur_intr || w_tmo_hit) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_id_nxt      = r_id;
        w_cpu_irq_nxt = r_cpu_irq;
        w_cpu_id_nxt  = r_cpu_id;
        w_irqres_nxt  = r_irqres;
        w_cnt_nxt     = r_cnt;
        w_err_set     = '0;
        case (r_state)
            S_IDLE: begin
                w_irqres_nxt  = '0;
                w_cpu_irq_nxt = 1'b0;
                if (|w_elig) begin
                    w_id_nxt      = w_winner;
                    w_cpu_irq_nxt = 1'b1;
                    w_cpu_id_nxt  = w_winner;
                end
            end
            S_PEND: begin
                // Withdraw takes precedence over a coincident ack.
                if (!w_cur_elig) begin
                    w_cpu_irq_nxt = 1'b0;
                end else if (i_cpu_ack) begin
                    w_cpu_irq_nxt = 1'b0;
                    w_irqres_nxt  = w_onehot;
                    w_cnt_nxt     = '0;
                end
            end
            S_CLEAR: begin
                if (w_pulse_done) begin
                    w_irqres_nxt = '0;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt    = w_cnt_inc;
                end
            end
            S_WAIT: begin
                w_irqres_nxt = '0;
                if (w_cur_intr) begin
                    if (w_tmo_hit) w_err_set[r_id] = 1'b1;
                    else           w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_irqres_nxt  = '0;
                w_cpu_irq_nxt = 1'b0;
            end
        endcase
    end

    assign o_cpu_irq = r_cpu_irq;
    assign o_cpu_id  = r_cpu_id;
    assign o_irqres  = r_irqres;
    assign o_busy    = r_busy;
    assign o_err     = r_err;

endmodule
